// File: rtl/div3_pkg.sv
// ============================================================================
// Module   : div3_pkg
// Purpose  : Shared constants and helpers for the odd-ratio 50% duty divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package div3_pkg;

   localparam int DIV_N_DEFAULT = 3;

   // Counter width for a mod-n counter; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Length of the shorter and longer part of the period, in whole clk cycles.
   function automatic int half_lo(input int n);
      return (n - 1) / 2;
   endfunction

   function automatic int half_hi(input int n);
      return (n + 1) / 2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/odd_clk_div3_if.sv
// ============================================================================
// Module   : odd_clk_div3_if
// Purpose  : Divided-clock output bundle (optional locked with DIV3_LOCK_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface odd_clk_div3_if;

   logic clk_out3_or;
   logic clk_out3_xor;
   logic clk_out3_and;
`ifdef DIV3_LOCK_EN
   logic locked;
`endif

   modport master (
      output clk_out3_or,
      output clk_out3_xor,
`ifdef DIV3_LOCK_EN
      output locked,
`endif
      output clk_out3_and
   );

   modport slave (
      input clk_out3_or,
      input clk_out3_xor,
`ifdef DIV3_LOCK_EN
      input locked,
`endif
      input clk_out3_and
   );

endinterface

`default_nettype wire

// File: rtl/div3_cnt.sv
// ============================================================================
// Module   : div3_cnt
// Purpose  : Mod-DIV_N counter with synchronous reset; exposes cnt and cnt_next.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div3_cnt
   import div3_pkg::*;
#(
   parameter int DIV_N = DIV_N_DEFAULT,
   parameter int CW    = cnt_width(DIV_N)
) (
   input  wire logic          clk,
   input  wire logic          rst,
   output logic [CW-1:0]      cnt,
   output logic [CW-1:0]      cnt_next
);

   localparam logic [CW-1:0] C_MAX = CW'(DIV_N - 1);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   always_comb begin
      cnt_next = (cnt == C_MAX) ? '0 : cnt + C_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/odd_clk_div3.sv
// ============================================================================
// Module   : odd_clk_div3
// Purpose  : Odd-ratio 50% duty clock divider with OR, XOR and AND schemes.
//            Optional locked output when DIV3_LOCK_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module odd_clk_div3
   import div3_pkg::*;
#(
   parameter int DIV_N = DIV_N_DEFAULT
) (
   input  wire logic          clk,
   input  wire logic          rst,
   odd_clk_div3_if.master     div_if
);

   localparam int            CW   = cnt_width(DIV_N);
   localparam logic [CW-1:0] C_H  = CW'(half_lo(DIV_N));
   localparam logic [CW-1:0] C_HP = CW'(half_hi(DIV_N));
   localparam logic [CW-1:0] C_MAX = CW'(DIV_N - 1);

   generate
      if ((DIV_N < 3) || ((DIV_N % 2) == 0)) begin : g_bad_div_n
         $error("odd_clk_div3: DIV_N must be odd and >= 3");
      end
   endgenerate

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   div3_cnt #(
      .DIV_N (DIV_N),
      .CW    (CW)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .cnt      (cnt),
      .cnt_next (cnt_next)
   );

   logic p_or, n_or;
   logic p_and, n_and;
   logic t_p, t_n;

   // Posedge halves: each scheme looks at the count that is about to be loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_or  <= 1'b0;
         p_and <= 1'b0;
         t_p   <= 1'b0;
      end else begin
         p_or  <= (cnt_next < C_H);
         p_and <= (cnt_next < C_HP);
         if (cnt == C_MAX) begin
            t_p <= ~t_p;
         end
      end
   end

   // Negedge halves delay the posedge flops by half a cycle, giving the x.5 high time.
   always_ff @(negedge clk) begin
      if (rst) begin
         n_or  <= 1'b0;
         n_and <= 1'b0;
         t_n   <= 1'b0;
      end else begin
         n_or  <= p_or;
         n_and <= p_and;
         if (cnt == C_H) begin
            t_n <= ~t_n;
         end
      end
   end

   assign div_if.clk_out3_or  = p_or | n_or;
   assign div_if.clk_out3_and = p_and & n_and;
   assign div_if.clk_out3_xor = t_p ^ t_n;

`ifdef DIV3_LOCK_EN
   logic locked_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         locked_r <= 1'b0;
      end else if (cnt == C_MAX) begin
         locked_r <= 1'b1;
      end
   end

   assign div_if.locked = locked_r;
`endif

endmodule

`default_nettype wire

// File: tb/tb_odd_clk_div3.sv
// ============================================================================
// Module   : tb_odd_clk_div3
// Purpose  : Directed self-checking bench for odd_clk_div3 (DIV_N = 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_odd_clk_div3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   odd_clk_div3_if div_if ();

   odd_clk_div3 #(.DIV_N(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .div_if (div_if)
   );

   always #5 clk = ~clk;

   // Expected levels per half-cycle k after the first released posedge
   // (k=0 is the half-cycle right after that posedge), hand-derived for DIV_N=3.
   function automatic logic exp_or(input int k);
      int m = k % 6;
      if (k == 0) return 1'b0;
      return (m == 4) || (m == 5) || (m == 0);
   endfunction

   function automatic logic exp_and(input int k);
      int m = k % 6;
      if (k == 0) return 1'b0;
      return (m == 5) || (m == 0) || (m == 1);
   endfunction

   function automatic logic exp_xor(input int k);
      int m = k % 6;
      return (m == 1) || (m == 2) || (m == 3);
   endfunction

   task automatic wait_until(input time t);
      while ($time < t) #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 4; i++) begin
         wait_until(12 + 10 * i);
         checks++;
         if ({div_if.clk_out3_or, div_if.clk_out3_and, div_if.clk_out3_xor} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold t=%0t got or/and/xor=%b%b%b want 000", $time,
                     div_if.clk_out3_or, div_if.clk_out3_and, div_if.clk_out3_xor);
         end
`ifdef DIV3_LOCK_EN
         checks++;
         if (div_if.locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_locked t=%0t got %b want 0", $time, div_if.locked);
         end
`endif
      end
      wait_until(41);
      rst = 1'b0;
   endtask

   task automatic test_schemes;
      for (int k = 0; k < 30; k++) begin
         wait_until(45 + 5 * k + 2);
         checks++;
         if (div_if.clk_out3_or !== exp_or(k)) begin
            errors++;
            $display("FAIL or_wave k=%0d got %b want %b", k, div_if.clk_out3_or, exp_or(k));
         end
         checks++;
         if (div_if.clk_out3_and !== exp_and(k)) begin
            errors++;
            $display("FAIL and_wave k=%0d got %b want %b", k, div_if.clk_out3_and, exp_and(k));
         end
         checks++;
         if (div_if.clk_out3_xor !== exp_xor(k)) begin
            errors++;
            $display("FAIL xor_wave k=%0d got %b want %b", k, div_if.clk_out3_xor, exp_xor(k));
         end
`ifdef DIV3_LOCK_EN
         checks++;
         if (div_if.locked !== (k >= 4)) begin
            errors++;
            $display("FAIL locked k=%0d got %b want %b", k, div_if.locked, (k >= 4));
         end
`endif
      end
   endtask

   task automatic test_mid_reset;
      wait_until(200);
      rst = 1'b1;
      wait_until(212);
      rst = 1'b0;
      checks++;
      if ({div_if.clk_out3_or, div_if.clk_out3_and, div_if.clk_out3_xor} !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset_clear got or/and/xor=%b%b%b want 000",
                  div_if.clk_out3_or, div_if.clk_out3_and, div_if.clk_out3_xor);
      end
`ifdef DIV3_LOCK_EN
      checks++;
      if (div_if.locked !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_locked got %b want 0", div_if.locked);
      end
`endif
      for (int k = 0; k < 18; k++) begin
         wait_until(215 + 5 * k + 2);
         checks++;
         if (div_if.clk_out3_or !== exp_or(k)) begin
            errors++;
            $display("FAIL restart_or k=%0d got %b want %b", k, div_if.clk_out3_or, exp_or(k));
         end
         checks++;
         if (div_if.clk_out3_and !== exp_and(k)) begin
            errors++;
            $display("FAIL restart_and k=%0d got %b want %b", k, div_if.clk_out3_and, exp_and(k));
         end
         checks++;
         if (div_if.clk_out3_xor !== exp_xor(k)) begin
            errors++;
            $display("FAIL restart_xor k=%0d got %b want %b", k, div_if.clk_out3_xor, exp_xor(k));
         end
`ifdef DIV3_LOCK_EN
         checks++;
         if (div_if.locked !== (k >= 4)) begin
            errors++;
            $display("FAIL restart_locked k=%0d got %b want %b", k, div_if.locked, (k >= 4));
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_schemes();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
